// File: rtl/fpu_pkg.sv
// Shared FP32 definitions for the adder scheduler and the adder test benches.
package fpu_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEND_A = 3'd1,
    SEND_B = 3'd2,
    WAIT_Z = 3'd3,
    RESP   = 3'd4
  } sched_state_t;

  localparam int          FP32_SIGN_BIT = 31;
  localparam logic [31:0] FP32_QNAN     = 32'hFFC0_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } fp_pair_t;

  function automatic logic [31:0] fp32_neg(input logic [31:0] x);
    return x ^ (32'h1 << FP32_SIGN_BIT);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from last_grant+1 and
// returns a one-hot grant plus its index.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  logic [ID_W:0] sum;

  // Walk the offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    grant_idx = last_grant;
    grant     = '0;
    sum       = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      sum = {1'b0, last_grant} + (ID_W+1)'(k);
      if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
      if (req[sum[ID_W-1:0]]) grant_idx = sum[ID_W-1:0];
    end
    if (|req) grant = NUM_REQ'(1) << grant_idx;
  end

endmodule

// File: rtl/fpu_adder_sched.sv
// Shares one FP32 adder between NUM_REQ requesters, one operation in flight,
// sequencing the adder's a/b/z handshakes and routing the result back.
module fpu_adder_sched
  import fpu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ-1:0]    req_op,
  input  logic [NUM_REQ*32-1:0] req_a,
  input  logic [NUM_REQ*32-1:0] req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    resp_valid,
  output logic [31:0]           resp_z,
  input  logic [NUM_REQ-1:0]    resp_ready,
  output logic                  busy,
  output logic [ID_W-1:0]       grant_id,
  output logic [31:0]           fpu_in_a,
  output logic                  fpu_in_a_req,
  input  logic                  fpu_in_a_ack,
  output logic [31:0]           fpu_in_b,
  output logic                  fpu_in_b_req,
  input  logic                  fpu_in_b_ack,
  input  logic [31:0]           fpu_out_z,
  input  logic                  fpu_out_z_req,
  output logic                  fpu_out_z_ack
);

  sched_state_t state_q, state_d;
  logic [ID_W-1:0] last_grant_q, last_grant_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  fp_pair_t ops_q, ops_d;
  logic [31:0] z_q, z_d;

  logic [NUM_REQ-1:0][31:0] req_a_v, req_b_v;
  logic [NUM_REQ-1:0] arb_grant;
  logic [ID_W-1:0] arb_idx;

  assign req_a_v = req_a;
  assign req_b_v = req_b;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    ops_d        = ops_q;
    z_d          = z_q;
    req_ready    = '0;
    case (state_q)
      IDLE: if (|req_valid) begin
        req_ready  = arb_grant;
        ops_d.a    = req_a_v[arb_idx];
        // Subtract is folded into an add by negating b.
        ops_d.b    = req_op[arb_idx] ? fp32_neg(req_b_v[arb_idx]) : req_b_v[arb_idx];
        grant_id_d = arb_idx;
        state_d    = SEND_A;
      end
      SEND_A: if (fpu_in_a_ack) state_d = SEND_B;
      SEND_B: if (fpu_in_b_ack) state_d = WAIT_Z;
      WAIT_Z: if (fpu_out_z_req) begin
        z_d     = fpu_out_z;
        state_d = RESP;
      end
      RESP: if (resp_ready[grant_id_q]) begin
        last_grant_d = grant_id_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ-1);
      grant_id_q   <= '0;
      ops_q        <= '0;
      z_q          <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      ops_q        <= ops_d;
      z_q          <= z_d;
    end
  end

  // Handshake outputs depend on registered state only.
  assign fpu_in_a      = ops_q.a;
  assign fpu_in_b      = ops_q.b;
  assign fpu_in_a_req  = (state_q == SEND_A);
  assign fpu_in_b_req  = (state_q == SEND_B);
  assign fpu_out_z_ack = (state_q == WAIT_Z);
  assign resp_valid    = (state_q == RESP) ? (NUM_REQ'(1) << grant_id_q) : '0;
  assign resp_z        = z_q;
  assign busy          = (state_q != IDLE);
  assign grant_id      = grant_id_q;

endmodule

// File: tb/tb_fpu_adder_sched.sv
// Randomized bench for fpu_adder_sched: behavioural adder, requester queues
// and a round-robin/scoreboard reference model.
module tb_fpu_adder_sched;
  import fpu_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_op = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_z;
  logic [N-1:0]    resp_ready = '1;
  logic            busy;
  logic [IW-1:0]   grant_id;
  logic [31:0]     fpu_in_a, fpu_in_b;
  logic            fpu_in_a_req, fpu_in_b_req, fpu_out_z_ack;
  logic            fpu_in_a_ack = 1'b0, fpu_in_b_ack = 1'b0, fpu_out_z_req = 1'b0;
  logic [31:0]     fpu_out_z = '0;

  always #5 clk = ~clk;

  fpu_adder_sched #(.NUM_REQ(N), .ID_W(IW)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_z(resp_z),
    .resp_ready(resp_ready), .busy(busy), .grant_id(grant_id),
    .fpu_in_a(fpu_in_a), .fpu_in_a_req(fpu_in_a_req), .fpu_in_a_ack(fpu_in_a_ack),
    .fpu_in_b(fpu_in_b), .fpu_in_b_req(fpu_in_b_req), .fpu_in_b_ack(fpu_in_b_ack),
    .fpu_out_z(fpu_out_z), .fpu_out_z_req(fpu_out_z_req), .fpu_out_z_ack(fpu_out_z_ack)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct { logic op; logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { int id; logic [31:0] z; } exp_t;

  op_t          src_q [N][$];
  exp_t         exp_q [$];
  int           grant_log [$];
  int           last_g_m = N-1;
  logic [N-1:0] rr_mask = '1;
  logic [N-1:0] acc_pend = '0;
  bit           rand_rr = 1'b0;
  logic [31:0]  last_z = '0;
  logic [31:0]  cap_a = '0, cap_b = '0;

  // Stand-in for the real adder: known test-plan results, a hash otherwise.
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    if (a == 32'h4040_0000 && b == 32'hBF80_0000) return 32'h4000_0000;
    if (a == 32'h7F80_0000 && b == 32'hFF80_0000) return FP32_QNAN;
    return (a ^ {b[15:0], b[31:16]}) + 32'h1357_9BDF;
  endfunction

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= N; k++)
      if (v[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic push(input int i, input logic op, input logic [31:0] a, input logic [31:0] b);
    op_t t;
    t.op = op; t.a = a; t.b = b;
    src_q[i].push_back(t);
  endtask

  // Adder model: random ack/compute latencies, driven at negedge.
  initial begin
    int phase, dly;
    phase = 0; dly = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        phase = 0; dly = int'($urandom_range(0, 3));
        fpu_in_a_ack = 1'b0; fpu_in_b_ack = 1'b0; fpu_out_z_req = 1'b0;
      end else begin
        case (phase)
          0: if (fpu_in_a_ack) begin
               fpu_in_a_ack = 1'b0; phase = 1; dly = int'($urandom_range(0, 3));
             end else if (fpu_in_a_req) begin
               if (dly == 0) begin cap_a = fpu_in_a; fpu_in_a_ack = 1'b1; end
               else dly--;
             end
          1: if (fpu_in_b_ack) begin
               fpu_in_b_ack = 1'b0; phase = 2; dly = int'($urandom_range(0, 6));
             end else if (fpu_in_b_req) begin
               if (dly == 0) begin cap_b = fpu_in_b; fpu_in_b_ack = 1'b1; end
               else dly--;
             end
          default: if (fpu_out_z_req) begin
               fpu_out_z_req = 1'b0; phase = 0; dly = int'($urandom_range(0, 3));
             end else if (dly == 0) begin
               chk("z_ack_in_wait", {31'b0, fpu_out_z_ack}, 32'd1);
               fpu_out_z = fadd(cap_a, cap_b); fpu_out_z_req = 1'b1;
             end else dly--;
        endcase
      end
    end
  end

  // Requester driver plus grant/response scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete(); acc_pend = '0; last_g_m = N-1;
      end
      for (int i = 0; i < N; i++)
        if (acc_pend[i]) void'(src_q[i].pop_front());
      acc_pend = '0;
      for (int i = 0; i < N; i++) begin
        req_valid[i] = (src_q[i].size() > 0);
        if (src_q[i].size() > 0) begin
          req_op[i] = src_q[i][0].op;
          req_a[32*i +: 32] = src_q[i][0].a;
          req_b[32*i +: 32] = src_q[i][0].b;
        end
      end
      if (rand_rr) rr_mask = N'($urandom);
      resp_ready = rr_mask;
      #1;
      if (!rst) begin
        if (!busy && |req_valid) begin
          int g;
          exp_t e;
          g = rr_pick(req_valid, last_g_m);
          chk("grant", {28'b0, req_ready}, 32'(1) << g);
          acc_pend[g] = 1'b1;
          e.id = g;
          e.z  = fadd(src_q[g][0].a, src_q[g][0].b ^ {src_q[g][0].op, 31'b0});
          exp_q.push_back(e);
          grant_log.push_back(g);
        end else if (busy) begin
          chk("ready_while_busy", {28'b0, req_ready}, 32'd0);
        end
        if (resp_valid != '0) begin
          if (exp_q.size() == 0) chk("spurious_resp", {28'b0, resp_valid}, 32'd0);
          else begin
            chk("resp_valid", {28'b0, resp_valid}, 32'(1) << exp_q[0].id);
            chk("resp_z", resp_z, exp_q[0].z);
            chk("grant_id", {30'b0, grant_id}, 32'(exp_q[0].id));
            if (resp_ready[exp_q[0].id]) begin
              last_g_m = exp_q[0].id;
              last_z   = resp_z;
              void'(exp_q.pop_front());
            end
          end
        end
      end
    end
  end

  task automatic drain(input int max_cyc);
    bit done;
    done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge clk); #2;
      done = (exp_q.size() == 0) && !busy;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) done = 1'b0;
    end
    chk("drain_done", {31'b0, done}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base;
    logic [31:0] hold_z;
    bit seen;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req_ready", {28'b0, req_ready}, 32'd0);
    chk("rst_resp_valid", {28'b0, resp_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_grant_id", {30'b0, grant_id}, 32'd0);
    chk("rst_hs", {29'b0, fpu_in_a_req, fpu_in_b_req, fpu_out_z_ack}, 32'd0);
    chk("rst_in_a", fpu_in_a, 32'd0);
    chk("rst_in_b", fpu_in_b, 32'd0);
    chk("rst_resp_z", resp_z, 32'd0);
    @(negedge clk); rst = 1'b0;

    push(0, 1'b0, 32'h3F80_0000, 32'h4000_0000);
    drain(200);
    chk("add_z", last_z, 32'h4040_0000);

    push(2, 1'b1, 32'h4040_0000, 32'h3F80_0000);
    drain(200);
    chk("sub_b_seen", cap_b, 32'hBF80_0000);
    chk("sub_z", last_z, 32'h4000_0000);

    push(1, 1'b0, 32'h7F80_0000, 32'hFF80_0000);
    drain(200);
    chk("nan_exp", {24'b0, last_z[30:23]}, 32'hFF);
    chk("nan_quiet", {31'b0, last_z[22]}, 32'd1);

    // Fairness from reset: everyone pending, two ops each.
    do_reset();
    grant_log.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) push(i, 1'($urandom), $urandom, $urandom);
    drain(1000);
    for (int k = 0; k < 6; k++)
      chk("fair_order", 32'(grant_log[k]), 32'(k % N));

    // Back-pressure on requester 1.
    rr_mask = 4'b1101;
    push(1, 1'b1, $urandom, $urandom);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk); #2;
      seen = resp_valid[1];
    end
    chk("bp_seen", {31'b0, seen}, 32'd1);
    push(0, 1'b0, $urandom, $urandom);
    push(3, 1'b0, $urandom, $urandom);
    hold_z = resp_z;
    repeat (20) begin
      @(negedge clk); #2;
      chk("bp_valid", {28'b0, resp_valid}, 32'b0010);
      chk("bp_z", resp_z, hold_z);
      chk("bp_busy", {31'b0, busy}, 32'd1);
      chk("bp_ready", {28'b0, req_ready}, 32'd0);
    end
    rr_mask = '1;
    drain(400);

    // Asynchronous reset while waiting on the result.
    push(3, 1'b0, $urandom, $urandom);
    seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      @(negedge clk); #1;
      seen = fpu_out_z_ack;
    end
    chk("wz_seen", {31'b0, seen}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_resp_valid", {28'b0, resp_valid}, 32'd0);
    chk("arst_hs", {29'b0, fpu_in_a_req, fpu_in_b_req, fpu_out_z_ack}, 32'd0);
    chk("arst_grant_id", {30'b0, grant_id}, 32'd0);
    chk("arst_req_ready", {28'b0, req_ready}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = grant_log.size();
    push(2, 1'b0, $urandom, $urandom);
    push(0, 1'b1, $urandom, $urandom);
    drain(400);
    chk("post_rst_first", 32'(grant_log[base]), 32'd0);
    chk("post_rst_second", 32'(grant_log[base+1]), 32'd2);

    // Random traffic with random response back-pressure.
    rand_rr = 1'b1;
    for (int k = 0; k < 40; k++) begin
      push(int'($urandom_range(0, N-1)), 1'($urandom), $urandom, $urandom);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    drain(4000);
    rand_rr = 1'b0;
    rr_mask = '1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
